rom_port_arbiter: RTL and testbench

//  Shares the single-port synchronous boot ROM between two read requesters:

---
 rtl/rom_port_arbiter_pkg.sv | 16 +
 rtl/rom_port_arbiter_rr_arb2.sv | 30 +++
 rtl/rom_port_arbiter.sv | 132 +++++++++++++
 tb/tb_rom_port_arbiter.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rom_port_arbiter_pkg.sv
// Shared definitions for the boot-ROM port arbiter.
//   arb_state_t : FSM state encoding (IDLE/ISSUE/CAPTURE/DONE)
//   PORT0/PORT1 : requester index values used for grant / last_grant
package rom_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } arb_state_t;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

endpackage

// File: rtl/rom_port_arbiter_rr_arb2.sv
// rr_arb2: combinational two-way arbiter pick.
//   req0, req1   : pending requests
//   last_grant   : index of the port served most recently
//   grant_valid  : at least one request present
//   grant_idx    : chosen port (PORT0/PORT1)
// With FIXED_PRIO set, port 0 always wins a contest; otherwise the port
// that was not served last wins, giving strict alternation under load.
module rr_arb2
  import rom_port_arbiter_pkg::*;
#(
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic req0,
  input  logic req1,
  input  logic last_grant,
  output logic grant_valid,
  output logic grant_idx
);

  always_comb begin
    grant_valid = req0 | req1;
    grant_idx   = PORT0;
    if (req0 && req1) begin
      grant_idx = FIXED_PRIO ? PORT0 : ~last_grant;
    end else if (req1) begin
      grant_idx = PORT1;
    end
  end

endmodule

// File: rtl/rom_port_arbiter.sv
// rom_port_arbiter: shares one single-port synchronous boot ROM between
// the CPU fetch path (port 0) and the debug monitor / loader (port 1).
//   CLK, RESET_N         : clock, async active-low reset
//   REQx / Ax            : level read request and address, held until ACKx
//   ACKx / DOx           : one-cycle data-valid pulse, data held until next ACKx
//   ROM_A/ROM_CS_N/OE_N  : ROM pin drive
//   ROM_DO               : ROM read data, one cycle after the address is registered
//   BUSY                 : high whenever the FSM is outside IDLE
//
// state   | meaning
// --------+----------------------------------------------------------
// IDLE    | wait for a request; pick port, latch its address
// ISSUE   | ROM enabled, ROM registers mem[ROM_A] at the closing edge
// CAPTURE | ROM still enabled so DO stays driven; capture into DOg, ACKg
// DONE    | ACK pulse visible, ROM disabled, requests not sampled
module rom_port_arbiter
  import rom_port_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = 14,
  parameter int DATA_WIDTH = 8,
  parameter int FIXED_PRIO = 0
) (
  input  logic                  CLK,
  input  logic                  RESET_N,
  input  logic                  REQ0,
  input  logic [ADDR_WIDTH-1:0] A0,
  output logic                  ACK0,
  output logic [DATA_WIDTH-1:0] DO0,
  input  logic                  REQ1,
  input  logic [ADDR_WIDTH-1:0] A1,
  output logic                  ACK1,
  output logic [DATA_WIDTH-1:0] DO1,
  output logic [ADDR_WIDTH-1:0] ROM_A,
  output logic                  ROM_CS_N,
  output logic                  ROM_OE_N,
  input  logic [DATA_WIDTH-1:0] ROM_DO,
  output logic                  BUSY
);

  arb_state_t            state, state_nxt;
  logic                  grant, grant_nxt;
  logic                  last_grant, last_grant_nxt;
  logic                  rom_en_nxt;
  logic [ADDR_WIDTH-1:0] rom_a_nxt;
  logic                  ack0_nxt, ack1_nxt;
  logic [DATA_WIDTH-1:0] do0_nxt, do1_nxt;
  logic                  pick_valid, pick_idx;

  rr_arb2 #(
    .FIXED_PRIO(FIXED_PRIO != 0)
  ) u_rr_arb2 (
    .req0       (REQ0),
    .req1       (REQ1),
    .last_grant (last_grant),
    .grant_valid(pick_valid),
    .grant_idx  (pick_idx)
  );

  // Every output is a flop; the comb block computes the value each output
  // takes in the next state, so pins never glitch.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state      <= ST_IDLE;
      grant      <= PORT0;
      last_grant <= PORT1;
      ROM_A      <= '0;
      ROM_CS_N   <= 1'b1;
      ROM_OE_N   <= 1'b1;
      ACK0       <= 1'b0;
      ACK1       <= 1'b0;
      DO0        <= '0;
      DO1        <= '0;
      BUSY       <= 1'b0;
    end else begin
      state      <= state_nxt;
      grant      <= grant_nxt;
      last_grant <= last_grant_nxt;
      ROM_A      <= rom_a_nxt;
      ROM_CS_N   <= ~rom_en_nxt;
      ROM_OE_N   <= ~rom_en_nxt;
      ACK0       <= ack0_nxt;
      ACK1       <= ack1_nxt;
      DO0        <= do0_nxt;
      DO1        <= do1_nxt;
      BUSY       <= (state_nxt != ST_IDLE);
    end
  end

  always_comb begin
    state_nxt      = state;
    grant_nxt      = grant;
    last_grant_nxt = last_grant;
    rom_a_nxt      = ROM_A;
    rom_en_nxt     = 1'b0;
    ack0_nxt       = 1'b0;
    ack1_nxt       = 1'b0;
    do0_nxt        = DO0;
    do1_nxt        = DO1;
    case (state)
      ST_IDLE: begin
        if (pick_valid) begin
          grant_nxt  = pick_idx;
          rom_a_nxt  = (pick_idx == PORT1) ? A1 : A0;
          rom_en_nxt = 1'b1;
          state_nxt  = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        rom_en_nxt = 1'b1;
        state_nxt  = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        if (grant == PORT1) begin
          do1_nxt  = ROM_DO;
          ack1_nxt = 1'b1;
        end else begin
          do0_nxt  = ROM_DO;
          ack0_nxt = 1'b1;
        end
        last_grant_nxt = grant;
        state_nxt      = ST_DONE;
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_rom_port_arbiter.sv
module tb_rom_port_arbiter;
  localparam int AW = 14;
  localparam int DW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          req0, req1, ack0, ack1, rom_cs_n, rom_oe_n, busy;
  logic [AW-1:0] a0, a1, rom_a;
  logic [DW-1:0] do0, do1, rom_q, rom_do;
  logic          f_req0, f_req1, f_ack0, f_ack1, f_rom_cs_n, f_rom_oe_n, f_busy;
  logic [AW-1:0] f_a0, f_a1, f_rom_a;
  logic [DW-1:0] f_do0, f_do1, f_rom_q, f_rom_do;

  int n_tests = 0;
  int n_fail  = 0;

  rom_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIXED_PRIO(0)) dut (
    .CLK(clk), .RESET_N(rst_n),
    .REQ0(req0), .A0(a0), .ACK0(ack0), .DO0(do0),
    .REQ1(req1), .A1(a1), .ACK1(ack1), .DO1(do1),
    .ROM_A(rom_a), .ROM_CS_N(rom_cs_n), .ROM_OE_N(rom_oe_n), .ROM_DO(rom_do),
    .BUSY(busy)
  );

  rom_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIXED_PRIO(1)) dut_fp (
    .CLK(clk), .RESET_N(rst_n),
    .REQ0(f_req0), .A0(f_a0), .ACK0(f_ack0), .DO0(f_do0),
    .REQ1(f_req1), .A1(f_a1), .ACK1(f_ack1), .DO1(f_do1),
    .ROM_A(f_rom_a), .ROM_CS_N(f_rom_cs_n), .ROM_OE_N(f_rom_oe_n), .ROM_DO(f_rom_do),
    .BUSY(f_busy)
  );

  // ROM models: mem[i] = i[7:0] ^ 8'hA5, one-cycle registered read.
  // An undriven bus is modelled as 8'hEE so early/late capture shows up.
  always @(posedge clk) if (!rom_cs_n)   rom_q   <= rom_a[7:0] ^ 8'hA5;
  always @(posedge clk) if (!f_rom_cs_n) f_rom_q <= f_rom_a[7:0] ^ 8'hA5;
  assign rom_do   = (!rom_cs_n && !rom_oe_n)     ? rom_q   : 8'hEE;
  assign f_rom_do = (!f_rom_cs_n && !f_rom_oe_n) ? f_rom_q : 8'hEE;

  task automatic check(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ack(input int sel, input int max_cyc, output int lat, output int port);
    lat  = -1;
    port = -1;
    for (int k = 1; k <= max_cyc; k++) begin
      if (lat < 0) begin
        tick();
        if (sel == 0 ? (ack0 || ack1) : (f_ack0 || f_ack1)) begin
          lat  = k;
          port = (sel == 0 ? ack1 : f_ack1) ? 1 : 0;
        end
      end
    end
  endtask

  // Bus protocol monitors, sampled mid-cycle for both instances.
  logic prev_cs[2] = '{1'b1, 1'b1};
  logic pend[2]    = '{1'b0, 1'b0};

  task automatic mon_fail(input int k, input string what, input logic act_bit);
    n_fail++;
    $display("FAIL mon%0d %s: actual %b required %b", k, what, act_bit, ~act_bit);
  endtask

  task automatic mon(input int k, input logic m_ack0, input logic m_ack1,
                     input logic cs, input logic oe, input logic bz);
    if (m_ack0 && m_ack1) mon_fail(k, "ack0_and_ack1", 1'b1);
    if ((!cs || !oe) && (!bz || m_ack0 || m_ack1)) mon_fail(k, "rom_enabled_outside_issue_capture", 1'b1);
    if (!rst_n) begin
      if (!cs || !oe) mon_fail(k, "rom_enabled_in_reset", 1'b1);
      pend[k] = 1'b0;
    end else begin
      if (prev_cs[k] && !cs) begin
        if (pend[k]) mon_fail(k, "grant_without_ack", pend[k]);
        pend[k] = 1'b1;
      end
      if (m_ack0 || m_ack1) begin
        if (!pend[k]) mon_fail(k, "ack_without_grant", 1'b1);
        pend[k] = 1'b0;
      end
    end
    prev_cs[k] = cs;
  endtask

  always @(negedge clk) begin
    mon(0, ack0, ack1, rom_cs_n, rom_oe_n, busy);
    mon(1, f_ack0, f_ack1, f_rom_cs_n, f_rom_oe_n, f_busy);
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic          r0;
    logic          r1;
    logic [AW-1:0] a0;
    logic [AW-1:0] a1;
    int            port;
    logic [DW-1:0] data;
  } vec_t;

  vec_t vt[8];

  initial begin
    int lat, port;
    logic [DW-1:0] held[2];

    // Round-robin history from reset: last_grant starts at port 1.
    vt[0] = '{r0:1'b1, r1:1'b0, a0:14'h0010, a1:14'h0000, port:0, data:8'hB5};
    vt[1] = '{r0:1'b0, r1:1'b1, a0:14'h0000, a1:14'h0123, port:1, data:8'h86};
    vt[2] = '{r0:1'b1, r1:1'b1, a0:14'h0001, a1:14'h0002, port:0, data:8'hA4};
    vt[3] = '{r0:1'b1, r1:1'b1, a0:14'h00FF, a1:14'h3F00, port:1, data:8'hA5};
    vt[4] = '{r0:1'b1, r1:1'b1, a0:14'h2A5A, a1:14'h0777, port:0, data:8'hFF};
    vt[5] = '{r0:1'b0, r1:1'b1, a0:14'h0000, a1:14'h3FFF, port:1, data:8'h5A};
    vt[6] = '{r0:1'b1, r1:1'b0, a0:14'h0000, a1:14'h0000, port:0, data:8'hA5};
    vt[7] = '{r0:1'b1, r1:1'b1, a0:14'h1234, a1:14'h0080, port:1, data:8'h25};

    rst_n = 1'b0;
    req0 = 1'b0; req1 = 1'b0; a0 = '0; a1 = '0;
    f_req0 = 1'b0; f_req1 = 1'b0; f_a0 = '0; f_a1 = '0;
    repeat (3) tick();

    check("rst cs_n", rom_cs_n, 1);
    check("rst oe_n", rom_oe_n, 1);
    check("rst rom_a", rom_a, 0);
    check("rst ack0", ack0, 0);
    check("rst ack1", ack1, 0);
    check("rst do0", do0, 0);
    check("rst do1", do1, 0);
    check("rst busy", busy, 0);
    rst_n = 1'b1;
    tick();
    check("post-rst busy", busy, 0);
    check("post-rst cs_n", rom_cs_n, 1);

    held[0] = '0;
    held[1] = '0;
    for (int i = 0; i < 8; i++) begin
      req0 = vt[i].r0; req1 = vt[i].r1; a0 = vt[i].a0; a1 = vt[i].a1;
      wait_ack(0, 10, lat, port);
      check($sformatf("vec%0d latency", i), lat, 3);
      check($sformatf("vec%0d port", i), port, vt[i].port);
      check($sformatf("vec%0d data", i), (vt[i].port == 1) ? do1 : do0, vt[i].data);
      check($sformatf("vec%0d other_do_held", i),
            (vt[i].port == 1) ? do0 : do1, (vt[i].port == 1) ? held[0] : held[1]);
      held[vt[i].port] = vt[i].data;
      req0 = 1'b0; req1 = 1'b0;
      tick();
      check($sformatf("vec%0d idle", i), busy, 0);
    end

    // Simultaneous requests straight after reset: port 0 first, port 1 four cycles later.
    rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
    req0 = 1'b1; a0 = 14'h0001; req1 = 1'b1; a1 = 14'h0002;
    wait_ack(0, 10, lat, port);
    check("both lat0", lat, 3);
    check("both port0", port, 0);
    check("both do0", do0, 8'hA4);
    req0 = 1'b0;
    wait_ack(0, 10, lat, port);
    check("both lat1", lat, 4);
    check("both port1", port, 1);
    check("both do1", do1, 8'hA7);

    // Continuous contention, round-robin: strict alternation starting at port 0.
    req0 = 1'b1; a0 = 14'h0100; a1 = 14'h0201;
    for (int k = 0; k < 8; k++) begin
      wait_ack(0, 10, lat, port);
      check($sformatf("rr%0d lat", k), lat, 4);
      check($sformatf("rr%0d port", k), port, k % 2);
      check($sformatf("rr%0d data", k), (k % 2 == 1) ? do1 : do0, (k % 2 == 1) ? 8'hA4 : 8'hA5);
    end
    req0 = 1'b0; req1 = 1'b0;
    tick();
    check("rr idle", busy, 0);

    // Fixed priority: port 1 starves while port 0 keeps requesting, then is served.
    f_req0 = 1'b1; f_req1 = 1'b1; f_a0 = 14'h0011; f_a1 = 14'h0022;
    for (int k = 0; k < 8; k++) begin
      wait_ack(1, 10, lat, port);
      check($sformatf("fp%0d lat", k), lat, (k == 0) ? 3 : 4);
      check($sformatf("fp%0d port", k), port, 0);
      check($sformatf("fp%0d data", k), f_do0, 8'hB4);
    end
    f_req0 = 1'b0;
    wait_ack(1, 10, lat, port);
    check("fp p1 lat", lat, 4);
    check("fp p1 port", port, 1);
    check("fp p1 data", f_do1, 8'h87);
    f_req1 = 1'b0;
    tick();
    check("fp idle", f_busy, 0);

    // Reset during CAPTURE of a port-1 read.
    req1 = 1'b1; a1 = 14'h0042;
    tick();
    tick();
    check("abort cs_low_in_capture", rom_cs_n, 0);
    check("abort do1_before", do1, 8'hA4);
    #2 rst_n = 1'b0; req1 = 1'b0;
    #1;
    check("abort cs_n", rom_cs_n, 1);
    check("abort oe_n", rom_oe_n, 1);
    check("abort do1", do1, 0);
    check("abort ack1", ack1, 0);
    check("abort busy", busy, 0);
    check("abort rom_a", rom_a, 0);
    tick();
    check("abort ack1 t1", ack1, 0);
    tick();
    check("abort ack1 t2", ack1, 0);
    rst_n = 1'b1;
    req0 = 1'b1; a0 = 14'h0010; req1 = 1'b1; a1 = 14'h0042;
    wait_ack(0, 10, lat, port);
    check("post-abort lat", lat, 3);
    check("post-abort port", port, 0);
    check("post-abort do0", do0, 8'hB5);
    check("post-abort do1 cleared", do1, 0);
    req0 = 1'b0;
    wait_ack(0, 10, lat, port);
    check("post-abort p1 lat", lat, 4);
    check("post-abort p1 port", port, 1);
    check("post-abort p1 data", do1, 8'hE7);
    req1 = 1'b0;
    tick();

    // Address changes after the grant are ignored.
    req0 = 1'b1; a0 = 14'h0055;
    tick();
    check("addr latched", rom_a, 14'h0055);
    a0 = 14'h3FFF;
    wait_ack(0, 10, lat, port);
    check("addr-chg lat", lat, 2);
    check("addr-chg port", port, 0);
    check("addr-chg do0", do0, 8'hF0);
    req0 = 1'b0;
    tick();

    // Request withdrawn before ACK still completes with one ACK.
    req1 = 1'b1; a1 = 14'h0033;
    tick();
    req1 = 1'b0;
    wait_ack(0, 10, lat, port);
    check("drop lat", lat, 2);
    check("drop port", port, 1);
    check("drop do1", do1, 8'h96);
    tick();
    check("drop idle", busy, 0);
    tick();
    check("drop no retrigger", busy, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
